// File: rtl/gemm_tile_sequencer.sv
// Walks the M/N/K tile loops of a tiled GEMM: issues A/B tile reads, waits for the datapath result, then issues the C tile write.
// Moore FSM with registered outputs; rd/wr requests use valid/ready, and stalled requests hold their fields until accepted.
module gemm_tile_sequencer #(
    parameter int AddrWidth  = 32,
    parameter int CntWidth   = 8,
    parameter int TileBytesA = 512,
    parameter int TileBytesB = 512,
    parameter int TileBytesC = 2048
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cfg_valid_i,
    output logic                 cfg_ready_o,
    input  logic [CntWidth-1:0]  cfg_m_i,
    input  logic [CntWidth-1:0]  cfg_k_i,
    input  logic [CntWidth-1:0]  cfg_n_i,
    input  logic [AddrWidth-1:0] cfg_base_a_i,
    input  logic [AddrWidth-1:0] cfg_base_b_i,
    input  logic [AddrWidth-1:0] cfg_base_c_i,
    output logic                 rd_valid_o,
    input  logic                 rd_ready_i,
    output logic [AddrWidth-1:0] rd_addr_a_o,
    output logic [AddrWidth-1:0] rd_addr_b_o,
    output logic                 acc_first_o,
    output logic                 acc_last_o,
    input  logic                 res_valid_i,
    output logic                 wr_valid_o,
    input  logic                 wr_ready_i,
    output logic [AddrWidth-1:0] wr_addr_c_o,
    output logic                 busy_o,
    output logic                 done_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT_RES,
        ST_WRITE,
        ST_DONE
    } state_e;

    localparam logic [AddrWidth-1:0] StrideA = AddrWidth'(TileBytesA);
    localparam logic [AddrWidth-1:0] StrideB = AddrWidth'(TileBytesB);
    localparam logic [AddrWidth-1:0] StrideC = AddrWidth'(TileBytesC);
    localparam logic [CntWidth-1:0]  CntOne  = CntWidth'(1);

    state_e                state_q, state_d;
    logic [CntWidth-1:0]   m_q, m_d, n_q, n_d, k_q, k_d;
    logic [CntWidth-1:0]   cfg_m_q, cfg_m_d, cfg_k_q, cfg_k_d, cfg_n_q, cfg_n_d;
    logic [AddrWidth-1:0]  base_a_q, base_a_d, base_b_q, base_b_d, base_c_q, base_c_d;

    logic                  cfg_ready_q, cfg_ready_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [AddrWidth-1:0]  rd_addr_a_q, rd_addr_a_d, rd_addr_b_q, rd_addr_b_d;
    logic                  acc_first_q, acc_first_d, acc_last_q, acc_last_d;
    logic                  wr_valid_q, wr_valid_d;
    logic [AddrWidth-1:0]  wr_addr_c_q, wr_addr_c_d;
    logic                  busy_q, busy_d, done_q, done_d;

    // Tile index outer*count+inner, computed at double counter width, zero-extended.
    function automatic logic [AddrWidth-1:0] tile_idx(
        input logic [CntWidth-1:0] outer,
        input logic [CntWidth-1:0] count,
        input logic [CntWidth-1:0] inner
    );
        logic [2*CntWidth-1:0] idx;
        idx = {{CntWidth{1'b0}}, outer} * {{CntWidth{1'b0}}, count}
            + {{CntWidth{1'b0}}, inner};
        return AddrWidth'(idx);
    endfunction

    always_comb begin
        state_d  = state_q;
        m_d      = m_q;
        n_d      = n_q;
        k_d      = k_q;
        cfg_m_d  = cfg_m_q;
        cfg_k_d  = cfg_k_q;
        cfg_n_d  = cfg_n_q;
        base_a_d = base_a_q;
        base_b_d = base_b_q;
        base_c_d = base_c_q;

        unique case (state_q)
            ST_IDLE: begin
                if (cfg_valid_i && cfg_ready_q) begin
                    cfg_m_d  = cfg_m_i;
                    cfg_k_d  = cfg_k_i;
                    cfg_n_d  = cfg_n_i;
                    base_a_d = cfg_base_a_i;
                    base_b_d = cfg_base_b_i;
                    base_c_d = cfg_base_c_i;
                    m_d      = '0;
                    n_d      = '0;
                    k_d      = '0;
                    if (cfg_m_i == '0 || cfg_k_i == '0 || cfg_n_i == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ: begin
                if (rd_ready_i) begin
                    if (k_q != cfg_k_q - CntOne) begin
                        k_d = k_q + CntOne;
                    end else begin
                        k_d     = '0;
                        state_d = ST_WAIT_RES;
                    end
                end
            end
            ST_WAIT_RES: begin
                if (res_valid_i) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (wr_ready_i) begin
                    state_d = ST_READ;
                    if (n_q != cfg_n_q - CntOne) begin
                        n_d = n_q + CntOne;
                    end else begin
                        n_d = '0;
                        if (m_q != cfg_m_q - CntOne) begin
                            m_d = m_q + CntOne;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Outputs are decoded from the next state so they appear registered.
        rd_valid_d  = (state_d == ST_READ);
        rd_addr_a_d = '0;
        rd_addr_b_d = '0;
        acc_first_d = 1'b0;
        acc_last_d  = 1'b0;
        if (rd_valid_d) begin
            rd_addr_a_d = base_a_d + StrideA * tile_idx(m_d, cfg_k_d, k_d);
            rd_addr_b_d = base_b_d + StrideB * tile_idx(n_d, cfg_k_d, k_d);
            acc_first_d = (k_d == '0);
            acc_last_d  = (k_d == cfg_k_d - CntOne);
        end
        wr_valid_d  = (state_d == ST_WRITE);
        wr_addr_c_d = '0;
        if (wr_valid_d) begin
            wr_addr_c_d = base_c_d + StrideC * tile_idx(m_d, cfg_n_d, n_d);
        end
        cfg_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_DONE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            m_q         <= '0;
            n_q         <= '0;
            k_q         <= '0;
            cfg_m_q     <= '0;
            cfg_k_q     <= '0;
            cfg_n_q     <= '0;
            base_a_q    <= '0;
            base_b_q    <= '0;
            base_c_q    <= '0;
            cfg_ready_q <= 1'b1;
            rd_valid_q  <= 1'b0;
            rd_addr_a_q <= '0;
            rd_addr_b_q <= '0;
            acc_first_q <= 1'b0;
            acc_last_q  <= 1'b0;
            wr_valid_q  <= 1'b0;
            wr_addr_c_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            m_q         <= m_d;
            n_q         <= n_d;
            k_q         <= k_d;
            cfg_m_q     <= cfg_m_d;
            cfg_k_q     <= cfg_k_d;
            cfg_n_q     <= cfg_n_d;
            base_a_q    <= base_a_d;
            base_b_q    <= base_b_d;
            base_c_q    <= base_c_d;
            cfg_ready_q <= cfg_ready_d;
            rd_valid_q  <= rd_valid_d;
            rd_addr_a_q <= rd_addr_a_d;
            rd_addr_b_q <= rd_addr_b_d;
            acc_first_q <= acc_first_d;
            acc_last_q  <= acc_last_d;
            wr_valid_q  <= wr_valid_d;
            wr_addr_c_q <= wr_addr_c_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign cfg_ready_o = cfg_ready_q;
    assign rd_valid_o  = rd_valid_q;
    assign rd_addr_a_o = rd_addr_a_q;
    assign rd_addr_b_o = rd_addr_b_q;
    assign acc_first_o = acc_first_q;
    assign acc_last_o  = acc_last_q;
    assign wr_valid_o  = wr_valid_q;
    assign wr_addr_c_o = wr_addr_c_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule

// File: doc/gemm_tile_sequencer.md
Name: gemm_tile_sequencer

Overview:
Sequences a tiled GEMM (C[M×N] += A[M×K]·B[K×N], in units of 8×8 tiles) over the GEMM datapath. Accepts one job configuration, then walks the M/N/K tile loops. For each step it issues A/B tile read requests and waits for the datapath accumulation result. It then issues the C tile write request. It sits between the CSR/config front-end and the GEMM datapath plus memory port, replacing free-running counters with valid/ready handshakes.

Parameters:
AddrWidth, 32, width of all addresses
CntWidth, 8, width of M/K/N and the loop counters
TileBytesA, 512, byte stride of one A tile
TileBytesB, 512, byte stride of one B tile
TileBytesC, 2048, byte stride of one C tile

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous, active-high reset
cfg_valid_i  in  1  job config valid
cfg_ready_o  out  1  config accepted; high only in IDLE
cfg_m_i / cfg_k_i / cfg_n_i  in  CntWidth  tile counts M, K, N
cfg_base_a_i / cfg_base_b_i / cfg_base_c_i  in  AddrWidth  matrix base addresses
rd_valid_o  out  1  A/B tile read request valid
rd_ready_i  in  1  read request accepted
rd_addr_a_o / rd_addr_b_o  out  AddrWidth  A/B tile addresses
acc_first_o  out  1  with rd_valid_o: k==0 (datapath clears accumulator)
acc_last_o  out  1  with rd_valid_o: k==K-1
res_valid_i  in  1  datapath finished accumulating current C tile
wr_valid_o  out  1  C tile write request valid
wr_ready_i  in  1  write request accepted
wr_addr_c_o  out  AddrWidth  C tile address
busy_o  out  1  state != IDLE
done_o  out  1  one-cycle pulse at job end

Behaviour:
- Moore FSM: IDLE, READ, WAIT_RES, WRITE, DONE. All outputs decode from registered state and counters.
- Reset (any cycle, including mid-job): the next state is IDLE.
  - Counters m, n, k and the latched config are cleared.
  - All outputs are 0 except cfg_ready_o=1.
  - No done_o pulse is generated.
- IDLE:
  - cfg_valid_i & cfg_ready_o in cycle t latches M, K, N and the three bases.
  - If any of M, K, N is 0, go to DONE (no rd/wr transactions). Otherwise zero m/n/k and go to READ, so rd_valid_o=1 at t+1.
  - cfg_valid_i outside IDLE is ignored.
- Loop order: m outer, n middle, k inner.
- READ:
  - rd_valid_o=1.
  - rd_addr_a_o = base_a + TileBytesA*(m*K+k).
  - rd_addr_b_o = base_b + TileBytesB*(n*K+k).
  - acc_first_o=(k==0), acc_last_o=(k==K-1).
  - On rd_valid_o & rd_ready_i: if k!=K-1, k++ and stay in READ (back-to-back reads at 1 per cycle). Else k=0 and go to WAIT_RES.
  - While rd_ready_i=0, the valid level, addresses and acc flags are held stable.
- WAIT_RES: res_valid_i=1 moves to WRITE. res_valid_i is ignored in all other states.
- WRITE:
  - wr_valid_o=1, wr_addr_c_o = base_c + TileBytesC*(m*N+n). The address is held until the handshake.
  - On handshake: if n!=N-1, n++ and go to READ.
  - Else n=0. If m!=M-1, m++ and go to READ. Else go to DONE.
- DONE: done_o=1 for exactly one cycle, then IDLE.
- Arithmetic:
  - Tile indices m*K+k and n*K+k are 2*CntWidth bits, zero-extended.
  - Address products and sums wrap modulo 2^AddrWidth.
  - Counters never exceed count-1, so there is no wrap inside the loops.
- Idle values: rd_addr_*, wr_addr_c_o and acc flags are 0 whenever the corresponding valid is 0.
- Totals: the job issues M*N*K reads and M*N writes.

Test Plan:
1. M=K=N=1, bases 0x1000/0x2000/0x3000, readies tied 1, res_valid_i 2 cycles after read. Expected:
   - One read at A=0x1000, B=0x2000 with acc_first_o=acc_last_o=1.
   - One write at 0x3000.
   - done_o pulses once, then cfg_ready_o=1.
2. M=2, N=2, K=3, bases 0, readies 1, res_valid_i 1 cycle after each WAIT_RES entry. Expected:
   - 12 reads and 4 writes.
   - 1st read A=0, B=0; 12th read A=0xA00, B=0xA00.
   - Writes at C=0x0, 0x800, 0x1000, 0x1800.
   - acc_first_o on reads 1, 4, 7, 10.
3. Backpressure: rd_ready_i held 0 for 5 cycles mid-K, then wr_ready_i held 0 for 3 cycles. Expected: valids stay high, addresses stable, counters frozen; sequence otherwise identical to scenario 2.
4. Config K=0, accepted at cycle t. Expected: no rd_valid_o/wr_valid_o, done_o=1 at t+1, cfg_ready_o=1 at t+2.
5. rst_i asserted for 1 cycle while in WAIT_RES. Expected:
   - All outputs 0 and cfg_ready_o=1 the next cycle.
   - A later res_valid_i is ignored.
   - A new config restarts at A=base_a, B=base_b.
6. cfg_valid_i pulsed with new values while busy, and res_valid_i pulsed during READ. Expected: both ignored; job completes with the original config and addresses.
